multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control unit for the multicycle MIPS core.
- Decodes the instruction-register opcode and funct fields and sequences the shared ALU across fetch, PC increment, branch-target, address and execute steps.
- Drives ALU control codes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- Consumes the ALU zero flag for BEQ and drives every datapath mux select and write enable.

Parameters:
- STATE_W, 4, width of the state register and of the debug state port.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  6  instruction[31:26], from the instruction register.
- funct  input  6  instruction[5:0], from the instruction register.
- zero  input  1  ALU zero flag.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  output  1  data-memory write enable.
- irwrite  output  1  instruction-register load enable.
- regdst  output  1  register-file write address select: 0 = rt, 1 = rd.
- memtoreg  output  1  register-file write data select: 0 = ALUOut, 1 = Data.
- regwrite  output  1  register-file write enable.
- alusrca  output  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  output  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- alucontrol  output  3  ALU operation code.
- pcsrc  output  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- pcen  output  1  PC register enable.
- illegal  output  1  unsupported opcode or funct seen this cycle.
- state  output  STATE_W  current state, for debug only.

Behaviour:
- Clocking and reset
  - Single clock; reset is synchronous and active-high.
  - On any clk edge with reset=1, state <= FETCH; reset overrides any transition, including mid-instruction.
  - While reset=1, all write enables (memwrite, irwrite, regwrite, pcen) and illegal are forced to 0. All other outputs show FETCH values.
  - Consequence: after reset, the first fetch commits on the first cycle with reset=0.
- Output style
  - Outputs are Moore, decoded from state only.
  - Exceptions: alucontrol depends on funct, pcen depends on zero, and illegal is as defined below.
  - Any output not listed for a state is 0.
- State outputs
  - FETCH: alusrcb=01, aluop=00, irwrite=1, pcwrite=1, pcsrc=00.
  - DECODE: alusrcb=11, aluop=00. This precomputes the branch target.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1, regdst=0.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10.
  - ALUWB: regdst=1, regwrite=funct_legal.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - ADDIWB: regwrite=1, regdst=0.
  - JUMP: pcsrc=10, pcwrite=1.
- Transitions
  - FETCH -> DECODE.
  - DECODE, by op:
    - 100011 LW or 101011 SW -> MEMADR.
    - 000000 R-type -> EXECUTE.
    - 000100 BEQ -> BRANCH.
    - 001000 ADDI -> ADDIEX.
    - 000010 J -> JUMP.
    - Any other op -> FETCH, with illegal=1 during that DECODE cycle. Net effect: the instruction is a NOP and the PC has already advanced.
  - MEMADR -> MEMRD if LW, MEMWR if SW.
  - MEMRD -> MEMWB.
  - EXECUTE -> ALUWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
  - Unused state encodings -> FETCH.
- PC enable
  - pcen = pcwrite | (branch & zero).
  - zero is sampled combinationally in BRANCH, where the ALU computes A-B.
- ALU control
  - aluop 00 -> 010 (ADD).
  - aluop 01 -> 110 (SUB).
  - aluop 10 decodes funct:
    - 100000 -> 010
    - 100010 -> 110
    - 100100 -> 000
    - 100101 -> 001
    - 101010 -> 111
    - Any other funct -> 010, with funct_legal=0.
  - illegal=1 in EXECUTE and in ALUWB when funct_legal=0.
  - An illegal funct still passes through ALUWB, but regwrite is suppressed.
- Latency in cycles, FETCH included:
  - LW 5; SW 4; R-type 4; ADDI 4; BEQ 3; J 3; illegal opcode 2.
- Input stability
  - op and funct are held stable by the instruction register from DECODE onward. The controller does not re-latch them.

Decomposition:
- Shared package mips_defs:
  - opcode constants: OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J.
  - funct constants.
  - ALU control codes: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT.
  - aluop codes.
  - state encoding enum.
- Sub-module alu_decoder: combinational, inputs aluop and funct, outputs alucontrol and funct_legal. It is reusable by a future pipelined decoder.
- The FSM and output decode stay in multicycle_controller.

Test Plan:
- Reset hold:
  - Stimulus: reset=1 for 3 cycles with op=000000.
  - Required: state=FETCH; pcen=irwrite=regwrite=memwrite=0.
  - Required on release: FETCH shows irwrite=1, pcen=1, alucontrol=010.
- R-type SUB:
  - Stimulus: op=000000, funct=100010.
  - Required: states FETCH, DECODE, EXECUTE, ALUWB.
  - Required: EXECUTE has alucontrol=110, alusrca=1, alusrcb=00.
  - Required: ALUWB has regwrite=1, regdst=1.
  - Repeat with funct=101010 and expect alucontrol=111; funct=100100 gives 000; funct=100101 gives 001.
- LW / SW:
  - LW (op=100011): 5-cycle sequence; MEMRD has iord=1; MEMWB has memtoreg=1, regwrite=1.
  - SW (op=101011): 4 cycles; MEMWR has memwrite=1 exactly one cycle.
- BEQ:
  - op=000100 with zero=1: BRANCH has pcen=1, pcsrc=01, alucontrol=110.
  - op=000100 with zero=0: BRANCH has pcen=0.
  - Both cases return to FETCH next.
- Illegal:
  - op=111111: DECODE has illegal=1, then FETCH; regwrite and memwrite never assert.
  - op=000000, funct=000000: illegal=1 in EXECUTE and ALUWB; regwrite stays 0.
- Reset mid-operation:
  - Stimulus: assert reset during MEMRD of LW.
  - Required: next state FETCH; MEMWB never occurs; no regwrite.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS encodings: opcodes, funct codes, ALU control codes and controller states.
// Imported by the multicycle controller and its ALU decoder.
package mips_defs;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALUCTL_W = 3;
  localparam int unsigned ALUOP_W  = 2;
  localparam int unsigned FSM_W    = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b111;

  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [FSM_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  // Per-state datapath controls before the zero-flag and ALU decode are folded in.
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    aluop_t     aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_supported(input logic [OP_W-1:0] o);
    case (o)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU control decode from aluop and funct.
// funct_legal depends on funct only, so callers may use it in any state.
module alu_decoder
  import mips_defs::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_legal
);

  logic [ALUCTL_W-1:0] funct_alu;

  // Kept apart from the aluop mux so funct_legal carries no path from aluop.
  always_comb begin
    funct_alu   = ALU_ADD;
    funct_legal = 1'b1;
    case (funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD:   alucontrol = ALU_ADD;
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: alucontrol = funct_alu;
      default:     alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute steps
// and drives all datapath selects and write enables (Moore, plus zero/funct terms).
module multicycle_controller
  import mips_defs::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [2:0]         alucontrol,
  output logic [1:0]         pcsrc,
  output logic               pcen,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctl;
  logic   funct_legal;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // During reset the outputs decode as FETCH regardless of the held state.
  always_comb begin
    ctl = '0;
    case (reset ? S_FETCH : state_q)
      S_FETCH: begin
        ctl.alusrcb = 2'b01;
        ctl.aluop   = ALUOP_ADD;
        ctl.irwrite = 1'b1;
        ctl.pcwrite = 1'b1;
        ctl.pcsrc   = 2'b00;
      end
      S_DECODE: begin
        ctl.alusrcb = 2'b11;
        ctl.aluop   = ALUOP_ADD;
        ctl.illegal = ~op_supported(op);
      end
      S_MEMADR, S_ADDIEX: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = 2'b10;
        ctl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: ctl.iord = 1'b1;
      S_MEMWB: begin
        ctl.memtoreg = 1'b1;
        ctl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctl.iord     = 1'b1;
        ctl.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = 2'b00;
        ctl.aluop   = ALUOP_FUNCT;
        ctl.illegal = ~funct_legal;
      end
      S_ALUWB: begin
        ctl.regdst   = 1'b1;
        ctl.regwrite = funct_legal;
        ctl.illegal  = ~funct_legal;
      end
      S_BRANCH: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = 2'b00;
        ctl.aluop   = ALUOP_SUB;
        ctl.pcsrc   = 2'b01;
        ctl.branch  = 1'b1;
      end
      S_ADDIWB: ctl.regwrite = 1'b1;
      S_JUMP: begin
        ctl.pcsrc   = 2'b10;
        ctl.pcwrite = 1'b1;
      end
      default: ctl = '0;
    endcase
    if (reset) begin
      ctl.memwrite = 1'b0;
      ctl.irwrite  = 1'b0;
      ctl.regwrite = 1'b0;
      ctl.pcwrite  = 1'b0;
      ctl.branch   = 1'b0;
      ctl.illegal  = 1'b0;
    end
  end

  alu_decoder u_alu_decoder (
    .aluop       (ctl.aluop),
    .funct       (funct),
    .alucontrol  (alucontrol),
    .funct_legal (funct_legal)
  );

  assign iord     = ctl.iord;
  assign memwrite = ctl.memwrite;
  assign irwrite  = ctl.irwrite;
  assign regdst   = ctl.regdst;
  assign memtoreg = ctl.memtoreg;
  assign regwrite = ctl.regwrite;
  assign alusrca  = ctl.alusrca;
  assign alusrcb  = ctl.alusrcb;
  assign pcsrc    = ctl.pcsrc;
  assign pcen     = ctl.pcwrite | (ctl.branch & zero);
  assign illegal  = ctl.illegal;
  assign state    = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// cycle by cycle and compares state and the full output vector.
module tb_multicycle_controller;
  import mips_defs::*;

  logic       clk = 1'b0;
  logic       reset, zero;
  logic [5:0] op, funct;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic [15:0] outs;
  int checks = 0;
  int failures = 0;

  // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,alucontrol,pcsrc,pcen,illegal}
  localparam logic [15:0] O_RST    = 16'b0000000_01_010_00_0_0;
  localparam logic [15:0] O_FETCH  = 16'b0010000_01_010_00_1_0;
  localparam logic [15:0] O_DECODE = 16'b0000000_11_010_00_0_0;
  localparam logic [15:0] O_DECILL = 16'b0000000_11_010_00_0_1;
  localparam logic [15:0] O_MEMADR = 16'b0000001_10_010_00_0_0;
  localparam logic [15:0] O_MEMRD  = 16'b1000000_00_010_00_0_0;
  localparam logic [15:0] O_MEMWB  = 16'b0000110_00_010_00_0_0;
  localparam logic [15:0] O_MEMWR  = 16'b1100000_00_010_00_0_0;
  localparam logic [15:0] O_ALUWB  = 16'b0001010_00_010_00_0_0;
  localparam logic [15:0] O_WBILL  = 16'b0001000_00_010_00_0_1;
  localparam logic [15:0] O_EXILL  = 16'b0000001_00_010_00_0_1;
  localparam logic [15:0] O_BRT    = 16'b0000001_00_110_01_1_0;
  localparam logic [15:0] O_BRNT   = 16'b0000001_00_110_01_0_0;
  localparam logic [15:0] O_ADDIWB = 16'b0000010_00_010_00_0_0;
  localparam logic [15:0] O_JUMP   = 16'b0000000_00_010_10_1_0;

  always #5 clk = ~clk;

  assign outs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, alucontrol, pcsrc, pcen, illegal};

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .alucontrol(alucontrol), .pcsrc(pcsrc), .pcen(pcen), .illegal(illegal), .state(state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; op = 6'b000000; funct = 6'b000000; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (state !== 4'(S_FETCH)) begin failures++; $display("FAIL reset_hold cyc%0d state got=%0d exp=%0d", i, state, 4'(S_FETCH)); end
      checks++; if (outs !== O_RST) begin failures++; $display("FAIL reset_hold cyc%0d outs got=%b exp=%b", i, outs, O_RST); end
    end
    reset = 1'b0;
    #1;
    checks++; if (state !== 4'(S_FETCH)) begin failures++; $display("FAIL reset_release state got=%0d exp=%0d", state, 4'(S_FETCH)); end
    checks++; if (outs !== O_FETCH) begin failures++; $display("FAIL reset_release outs got=%b exp=%b", outs, O_FETCH); end
  endtask

  task automatic test_rtype(input logic [5:0] fn, input logic [2:0] alu, input string name);
    logic [3:0]  es [0:3];
    logic [15:0] eo [0:3];
    op = 6'b000000; funct = fn; zero = 1'b0;
    es[0] = 4'(S_FETCH);   eo[0] = O_FETCH;
    es[1] = 4'(S_DECODE);  eo[1] = O_DECODE;
    es[2] = 4'(S_EXECUTE); eo[2] = {7'b0000001, 2'b00, alu, 2'b00, 1'b0, 1'b0};
    es[3] = 4'(S_ALUWB);   eo[3] = O_ALUWB;
    for (int i = 0; i < 4; i++) begin
      checks++; if (state !== es[i]) begin failures++; $display("FAIL %s cyc%0d state got=%0d exp=%0d", name, i, state, es[i]); end
      checks++; if (outs !== eo[i]) begin failures++; $display("FAIL %s cyc%0d outs got=%b exp=%b", name, i, outs, eo[i]); end
      step();
    end
  endtask

  task automatic test_lw();
    logic [3:0]  es [0:4];
    logic [15:0] eo [0:4];
    op = 6'b100011; funct = 6'b000000; zero = 1'b0;
    es[0] = 4'(S_FETCH);  eo[0] = O_FETCH;
    es[1] = 4'(S_DECODE); eo[1] = O_DECODE;
    es[2] = 4'(S_MEMADR); eo[2] = O_MEMADR;
    es[3] = 4'(S_MEMRD);  eo[3] = O_MEMRD;
    es[4] = 4'(S_MEMWB);  eo[4] = O_MEMWB;
    for (int i = 0; i < 5; i++) begin
      checks++; if (state !== es[i]) begin failures++; $display("FAIL lw cyc%0d state got=%0d exp=%0d", i, state, es[i]); end
      checks++; if (outs !== eo[i]) begin failures++; $display("FAIL lw cyc%0d outs got=%b exp=%b", i, outs, eo[i]); end
      step();
    end
  endtask

  // zero held high to show it has no effect outside BRANCH
  task automatic test_sw();
    logic [3:0]  es [0:3];
    logic [15:0] eo [0:3];
    op = 6'b101011; funct = 6'b101010; zero = 1'b1;
    es[0] = 4'(S_FETCH);  eo[0] = O_FETCH;
    es[1] = 4'(S_DECODE); eo[1] = O_DECODE;
    es[2] = 4'(S_MEMADR); eo[2] = O_MEMADR;
    es[3] = 4'(S_MEMWR);  eo[3] = O_MEMWR;
    for (int i = 0; i < 4; i++) begin
      checks++; if (state !== es[i]) begin failures++; $display("FAIL sw cyc%0d state got=%0d exp=%0d", i, state, es[i]); end
      checks++; if (outs !== eo[i]) begin failures++; $display("FAIL sw cyc%0d outs got=%b exp=%b", i, outs, eo[i]); end
      step();
    end
    zero = 1'b0;
  endtask

  task automatic test_beq(input logic z);
    logic [3:0]  es [0:2];
    logic [15:0] eo [0:2];
    op = 6'b000100; funct = 6'b100101; zero = z;
    es[0] = 4'(S_FETCH);  eo[0] = O_FETCH;
    es[1] = 4'(S_DECODE); eo[1] = O_DECODE;
    es[2] = 4'(S_BRANCH); eo[2] = z ? O_BRT : O_BRNT;
    for (int i = 0; i < 3; i++) begin
      checks++; if (state !== es[i]) begin failures++; $display("FAIL beq_z%0d cyc%0d state got=%0d exp=%0d", z, i, state, es[i]); end
      checks++; if (outs !== eo[i]) begin failures++; $display("FAIL beq_z%0d cyc%0d outs got=%b exp=%b", z, i, outs, eo[i]); end
      step();
    end
    zero = 1'b0;
  endtask

  task automatic test_addi();
    logic [3:0]  es [0:3];
    logic [15:0] eo [0:3];
    op = 6'b001000; funct = 6'b100010; zero = 1'b0;
    es[0] = 4'(S_FETCH);  eo[0] = O_FETCH;
    es[1] = 4'(S_DECODE); eo[1] = O_DECODE;
    es[2] = 4'(S_ADDIEX); eo[2] = O_MEMADR;
    es[3] = 4'(S_ADDIWB); eo[3] = O_ADDIWB;
    for (int i = 0; i < 4; i++) begin
      checks++; if (state !== es[i]) begin failures++; $display("FAIL addi cyc%0d state got=%0d exp=%0d", i, state, es[i]); end
      checks++; if (outs !== eo[i]) begin failures++; $display("FAIL addi cyc%0d outs got=%b exp=%b", i, outs, eo[i]); end
      step();
    end
  endtask

  task automatic test_jump();
    logic [3:0]  es [0:2];
    logic [15:0] eo [0:2];
    op = 6'b000010; funct = 6'b000000; zero = 1'b0;
    es[0] = 4'(S_FETCH);  eo[0] = O_FETCH;
    es[1] = 4'(S_DECODE); eo[1] = O_DECODE;
    es[2] = 4'(S_JUMP);   eo[2] = O_JUMP;
    for (int i = 0; i < 3; i++) begin
      checks++; if (state !== es[i]) begin failures++; $display("FAIL jump cyc%0d state got=%0d exp=%0d", i, state, es[i]); end
      checks++; if (outs !== eo[i]) begin failures++; $display("FAIL jump cyc%0d outs got=%b exp=%b", i, outs, eo[i]); end
      step();
    end
  endtask

  task automatic test_illegal_op();
    logic [3:0]  es [0:2];
    logic [15:0] eo [0:2];
    op = 6'b111111; funct = 6'b100000; zero = 1'b0;
    es[0] = 4'(S_FETCH);  eo[0] = O_FETCH;
    es[1] = 4'(S_DECODE); eo[1] = O_DECILL;
    es[2] = 4'(S_FETCH);  eo[2] = O_FETCH;
    for (int i = 0; i < 3; i++) begin
      checks++; if (state !== es[i]) begin failures++; $display("FAIL illegal_op cyc%0d state got=%0d exp=%0d", i, state, es[i]); end
      checks++; if (outs !== eo[i]) begin failures++; $display("FAIL illegal_op cyc%0d outs got=%b exp=%b", i, outs, eo[i]); end
      if (i < 2) step();
    end
  endtask

  task automatic test_illegal_funct();
    logic [3:0]  es [0:3];
    logic [15:0] eo [0:3];
    op = 6'b000000; funct = 6'b000000; zero = 1'b0;
    es[0] = 4'(S_FETCH);   eo[0] = O_FETCH;
    es[1] = 4'(S_DECODE);  eo[1] = O_DECODE;
    es[2] = 4'(S_EXECUTE); eo[2] = O_EXILL;
    es[3] = 4'(S_ALUWB);   eo[3] = O_WBILL;
    for (int i = 0; i < 4; i++) begin
      checks++; if (state !== es[i]) begin failures++; $display("FAIL illegal_funct cyc%0d state got=%0d exp=%0d", i, state, es[i]); end
      checks++; if (outs !== eo[i]) begin failures++; $display("FAIL illegal_funct cyc%0d outs got=%b exp=%b", i, outs, eo[i]); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    op = 6'b100011; funct = 6'b000000; zero = 1'b0;
    step(); step(); step();
    checks++; if (state !== 4'(S_MEMRD)) begin failures++; $display("FAIL reset_mid memrd state got=%0d exp=%0d", state, 4'(S_MEMRD)); end
    reset = 1'b1;
    #1;
    checks++; if (outs !== O_RST) begin failures++; $display("FAIL reset_mid forced outs got=%b exp=%b", outs, O_RST); end
    step();
    checks++; if (state !== 4'(S_FETCH)) begin failures++; $display("FAIL reset_mid next state got=%0d exp=%0d", state, 4'(S_FETCH)); end
    checks++; if (regwrite !== 1'b0) begin failures++; $display("FAIL reset_mid regwrite got=%b exp=0", regwrite); end
    reset = 1'b0;
    #1;
    checks++; if (outs !== O_FETCH) begin failures++; $display("FAIL reset_mid release outs got=%b exp=%b", outs, O_FETCH); end
    step();
    checks++; if (state !== 4'(S_DECODE)) begin failures++; $display("FAIL reset_mid refetch state got=%0d exp=%0d", state, 4'(S_DECODE)); end
    step(); step(); step(); step();
  endtask

  initial begin
    test_reset();
    test_rtype(6'b100010, 3'b110, "rtype_sub");
    test_rtype(6'b101010, 3'b111, "rtype_slt");
    test_rtype(6'b100100, 3'b000, "rtype_and");
    test_rtype(6'b100101, 3'b001, "rtype_or");
    test_rtype(6'b100000, 3'b010, "rtype_add");
    test_lw();
    test_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_addi();
    test_jump();
    test_illegal_op();
    test_illegal_funct();
    test_reset_mid();
    checks++; if (state !== 4'(S_FETCH)) begin failures++; $display("FAIL final state got=%0d exp=%0d", state, 4'(S_FETCH)); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
